crack_ctl: RTL

Parametrised key-search controller for the ARC4 decryption circuit. It walks a key sub-space defined by a start key and a stride. For each candidate it drives an external `arc4` engine through its en/rdy handshake, then scans the length-prefixed plaintext memory for readable characters. It reports the first key whose plaintext is fully readable, or reports exhaustion. The stride lets N instances split the key space for parallel cracking.

---
 rtl/crack_ctl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/crack_ctl.sv
// Key-search controller for the ARC4 cracker: walks start/stride key sub-space,
// runs an external arc4 engine per candidate and scans plaintext for readable text.
module crack_ctl #(
  parameter int          KEY_WIDTH = 24,
  parameter logic [7:0]  MIN_CHAR  = 8'h20,
  parameter logic [7:0]  MAX_CHAR  = 8'h7E
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 rdy,
  input  logic [KEY_WIDTH-1:0] key_start,
  input  logic [KEY_WIDTH-1:0] key_stride,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 key_valid,
  output logic                 done,
  output logic [KEY_WIDTH-1:0] keys_tried,
  output logic                 a4_en,
  input  logic                 a4_rdy,
  output logic [KEY_WIDTH-1:0] a4_key,
  output logic [7:0]           pt_addr,
  input  logic [7:0]           pt_rddata
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_DROP = 3'd2;
  localparam logic [2:0] S_WAIT_A4   = 3'd3;
  localparam logic [2:0] S_RD_LEN    = 3'd4;
  localparam logic [2:0] S_SCAN      = 3'd5;
  localparam logic [2:0] S_ADVANCE   = 3'd6;

  logic [2:0]           state;
  logic [KEY_WIDTH-1:0] stride;
  logic [7:0]           len;
  logic [7:0]           idx;
  logic [KEY_WIDTH:0]   sum;
  logic [KEY_WIDTH-1:0] tried_inc;
  logic                 byte_ok;

  assign sum       = {1'b0, key} + {1'b0, stride};
  assign tried_inc = (&keys_tried) ? keys_tried : keys_tried + KEY_WIDTH'(1);
  assign byte_ok   = (pt_rddata >= MIN_CHAR) && (pt_rddata <= MAX_CHAR);

  assign rdy    = (state == S_IDLE);
  assign a4_en  = (state == S_LAUNCH) && a4_rdy;
  assign a4_key = key;

  // Address is combinational so the synchronous memory returns byte i while
  // the byte for i-1 is being judged; it is clamped so it never passes len.
  always_comb begin
    pt_addr = 8'd0;
    case (state)
      S_RD_LEN: pt_addr = (pt_rddata != 8'd0) ? 8'd1 : 8'd0;
      S_SCAN:   pt_addr = (idx == len) ? idx : idx + 8'd1;
      default:  pt_addr = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      key        <= '0;
      stride     <= '0;
      len        <= '0;
      idx        <= '0;
      keys_tried <= '0;
      done       <= 1'b0;
      key_valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            key        <= key_start;
            stride     <= key_stride;
            done       <= 1'b0;
            key_valid  <= 1'b0;
            keys_tried <= '0;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (a4_rdy) state <= S_WAIT_DROP;
        end
        S_WAIT_DROP: state <= S_WAIT_A4;
        S_WAIT_A4: begin
          if (a4_rdy) state <= S_RD_LEN;
        end
        S_RD_LEN: begin
          len <= pt_rddata;
          idx <= 8'd1;
          if (pt_rddata == 8'd0) begin
            key_valid  <= 1'b1;
            done       <= 1'b1;
            keys_tried <= tried_inc;
            state      <= S_IDLE;
          end else begin
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!byte_ok) begin
            state <= S_ADVANCE;
          end else if (idx == len) begin
            key_valid  <= 1'b1;
            done       <= 1'b1;
            keys_tried <= tried_inc;
            state      <= S_IDLE;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        S_ADVANCE: begin
          keys_tried <= tried_inc;
          if (sum[KEY_WIDTH] || (stride == '0)) begin
            done      <= 1'b1;
            key_valid <= 1'b0;
            state     <= S_IDLE;
          end else begin
            key   <= sum[KEY_WIDTH-1:0];
            state <= S_LAUNCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
